c3lib_gf_clkmux_ctrl: RTL and testbench

C3LIB_GF_CLKMUX_CTRL -- requirements
Module: c3lib_gf_clkmux_ctrl

---
 rtl/c3lib_gf_clkmux_pkg.sv | 22 ++
 rtl/c3lib_gf_clkmux_ctrl_bitsync.sv | 25 ++
 rtl/c3lib_gf_clkmux_ctrl.sv | 149 ++++++++++++++
 tb/tb_c3lib_gf_clkmux_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c3lib_gf_clkmux_pkg.sv
// Shared types and limits for the glitch-free clock-mux switch controller.
package c3lib_gf_clkmux_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_OFF = 3'd1,
    WAIT_ON  = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } clkmux_state_t;

  // Keeps an out-of-range depth from building a useless or oversized synchronizer.
  function automatic int clamp_sync_stages(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/c3lib_gf_clkmux_ctrl_bitsync.sv
// Multi-flop synchronizer (c3lib_bitsync) with synchronous reset to RESET_VAL.
module c3lib_bitsync #(
  parameter int                DWIDTH     = 1,
  parameter logic [DWIDTH-1:0] RESET_VAL  = '0,
  parameter int                SYNCSTAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out
);

  logic [SYNCSTAGES-1:0][DWIDTH-1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {SYNCSTAGES{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[SYNCSTAGES-2:0], data_in};
    end
  end

  assign data_out = stage_reg[SYNCSTAGES-1];

endmodule

// File: rtl/c3lib_gf_clkmux_ctrl.sv
// Switch controller for a glitch-free clock mux: drives the select and tracks the
// mux gate enables. Timeout/ERR logic is built only with C3LIB_GF_CLKMUX_CTRL_TIMEOUT_EN.
module c3lib_gf_clkmux_ctrl
  import c3lib_gf_clkmux_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   TIMEOUT_CYC = 1024,
  parameter logic RESET_SEL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw_req,
  input  logic i_sw_target,
  input  logic i_en_a_stat,
  input  logic i_en_b_stat,
  input  logic i_err_clr,
  output logic o_sel_clk,
  output logic o_busy,
  output logic o_sw_done,
  output logic o_sw_err
);

  localparam int SYNC_DEPTH = clamp_sync_stages(SYNC_STAGES);

  logic [1:0]    stat_async;
  logic [1:0]    stat_sync;
  clkmux_state_t state_reg, state_next;
  logic          sel_reg, sel_next;
  logic          old_off;
  logic          new_on;
  logic          timeout;

  // Bit 0 tracks clock A, bit 1 tracks clock B.
  assign stat_async = {i_en_b_stat, i_en_a_stat};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      c3lib_bitsync #(
        .DWIDTH    (1),
        .RESET_VAL (1'b0),
        .SYNCSTAGES(SYNC_DEPTH)
      ) u_sync (
        .clk     (i_clk),
        .rst     (i_rst),
        .data_in (stat_async[gi]),
        .data_out(stat_sync[gi])
      );
    end
  endgenerate

  // sel_reg already holds the new target while switching, so the old clock is the other one.
  assign old_off = sel_reg ? ~stat_sync[0] : ~stat_sync[1];
  assign new_on  = sel_reg ?  stat_sync[1] :  stat_sync[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      sel_reg   <= RESET_SEL;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        if (i_sw_req) begin
          if (i_sw_target != sel_reg) begin
            sel_next   = i_sw_target;
            state_next = WAIT_OFF;
          end else begin
            state_next = DONE;
          end
        end
      end
      WAIT_OFF: begin
        // A met exit condition wins over a simultaneous timeout.
        if (old_off) begin
          state_next = WAIT_ON;
        end else if (timeout) begin
          state_next = ERR;
        end
      end
      WAIT_ON: begin
        if (new_on) begin
          state_next = DONE;
        end else if (timeout) begin
          state_next = ERR;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      ERR: begin
        if (i_err_clr) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef C3LIB_GF_CLKMUX_CTRL_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
  // ERR is taken on the edge where the counter would reach TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cnt_clr;
  logic             cnt_inc;

  assign cnt_clr = (state_reg == IDLE) && (state_next == WAIT_OFF);
  assign cnt_inc = (state_reg == WAIT_OFF) || (state_reg == WAIT_ON);
  assign timeout = (cnt_reg == CNT_TRIP);

  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clr) begin
      cnt_next = '0;
    end else if (cnt_inc && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign o_sw_err = (state_reg == ERR);
`else
  assign timeout  = 1'b0;
  assign o_sw_err = 1'b0;
`endif

  assign o_sel_clk = sel_reg;
  assign o_busy    = (state_reg != IDLE);
  assign o_sw_done = (state_reg == DONE);

endmodule

// File: tb/tb_c3lib_gf_clkmux_ctrl.sv
// Self-checking bench for c3lib_gf_clkmux_ctrl (SYNC_STAGES=2, TIMEOUT_CYC=16); covers
// either the timeout or the unbounded-wait build depending on C3LIB_GF_CLKMUX_CTRL_TIMEOUT_EN.
module tb_c3lib_gf_clkmux_ctrl;

  localparam int S = 2;
  localparam int T = 16;
`ifdef C3LIB_GF_CLKMUX_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, req, tgt, a, b, clr;
  logic sel, busy, done, err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  c3lib_gf_clkmux_ctrl #(
    .SYNC_STAGES(S),
    .TIMEOUT_CYC(T),
    .RESET_SEL  (1'b0)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sw_req   (req),
    .i_sw_target(tgt),
    .i_en_a_stat(a),
    .i_en_b_stat(b),
    .i_err_clr  (clr),
    .o_sel_clk  (sel),
    .o_busy     (busy),
    .o_sw_done  (done),
    .o_sw_err   (err)
  );

  // Reference model: phase 0 idle, 1 waiting for old clock off, 2 waiting for new
  // clock on, 3 done pulse, 4 error. Status seen by the controller is the input S edges ago.
  int   m_phase;
  logic m_sel;
  int   m_cnt;
  logic a_hist[$];
  logic b_hist[$];

  function automatic void model_reset();
    m_phase = 0;
    m_sel   = 1'b0;
    m_cnt   = 0;
    a_hist.delete();
    b_hist.delete();
    for (int i = 0; i < S; i++) begin
      a_hist.push_back(1'b0);
      b_hist.push_back(1'b0);
    end
  endfunction

  function automatic void model_edge();
    logic sa, sb, old_on, new_on;
    if (rst) begin
      model_reset();
      return;
    end
    sa = a_hist[0];
    sb = b_hist[0];
    void'(a_hist.pop_front());
    void'(b_hist.pop_front());
    a_hist.push_back(a);
    b_hist.push_back(b);
    old_on = m_sel ? sa : sb;
    new_on = m_sel ? sb : sa;
    case (m_phase)
      0: if (req) begin
           if (tgt != m_sel) begin
             m_sel   = tgt;
             m_cnt   = 0;
             m_phase = 1;
           end else begin
             m_phase = 3;
           end
         end
      1, 2: begin
        m_cnt = m_cnt + 1;
        if ((m_phase == 1 && !old_on) || (m_phase == 2 && new_on)) m_phase = m_phase + 1;
        else if (TO_EN && m_cnt >= T - 1) m_phase = 4;
      end
      3: m_phase = 0;
      default: if (clr) m_phase = 0;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic rst, req, tgt, a, b;
    logic sel, busy, done, err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   bad_sel, bad_err, bad_busy;
    vec_t v;

    // Inputs {rst,req,tgt,a,b} and outputs {sel,busy,done,err} after the edge.
    // The mux enables follow o_sel_clk one edge later (vectors 5 -> 6).
    vecs[0]  = 9'b1_0_0_1_0_0_0_0_0;
    vecs[1]  = 9'b1_0_0_1_0_0_0_0_0;
    vecs[2]  = 9'b0_0_0_1_0_0_0_0_0;
    vecs[3]  = 9'b0_0_0_1_0_0_0_0_0;
    vecs[4]  = 9'b0_1_1_1_0_1_1_0_0;
    vecs[5]  = 9'b0_0_0_1_0_1_1_0_0;
    vecs[6]  = 9'b0_0_0_0_1_1_1_0_0;
    vecs[7]  = 9'b0_0_0_0_1_1_1_0_0;
    vecs[8]  = 9'b0_0_0_0_1_1_1_0_0;
    vecs[9]  = 9'b0_0_0_0_1_1_1_1_0;
    vecs[10] = 9'b0_0_0_0_1_1_0_0_0;
    vecs[11] = 9'b0_1_1_0_1_1_1_1_0;
    vecs[12] = 9'b0_0_0_0_1_1_0_0_0;

    rst = 1'b1; req = 1'b0; tgt = 1'b0; a = 1'b1; b = 1'b0; clr = 1'b0;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      rst = v.rst; req = v.req; tgt = v.tgt; a = v.a; b = v.b;
      cycle();
      $display("vec %0d: sel=%b busy=%b done=%b err=%b", i, sel, busy, done, err);
      chk($sformatf("vec%0d sel", i), sel, v.sel);
      chk($sformatf("vec%0d busy", i), busy, v.busy);
      chk($sformatf("vec%0d done", i), done, v.done);
      chk($sformatf("vec%0d err", i), err, v.err);
    end

    // Second request while busy is ignored; completion time unchanged.
    req = 1'b1; tgt = 1'b0;
    cycle();
    n = 1;
    req = 1'b1; tgt = 1'b1;
    cycle();
    n++;
    chk("busy_req sel", sel, 1'b0);
    req = 1'b0; a = 1'b1; b = 1'b0;
    bad_sel = 0;
    while (done !== 1'b1 && n < 40) begin
      cycle();
      n++;
      if (sel !== 1'b0) bad_sel++;
    end
    $display("busy_req: done after %0d cycles sel=%b", n, sel);
    chk_int("busy_req latency", n, 6);
    chk_int("busy_req sel toggles", bad_sel, 0);
    cycle();

    // Reset while waiting for the new clock.
    req = 1'b1; tgt = 1'b1;
    cycle();
    req = 1'b0; a = 1'b0;
    repeat (3) cycle();
    chk("wait_on busy", busy, 1'b1);
    rst = 1'b1;
    cycle();
    $display("mid_reset: sel=%b busy=%b done=%b err=%b", sel, busy, done, err);
    chk("mid_reset sel", sel, 1'b0);
    chk("mid_reset busy", busy, 1'b0);
    chk("mid_reset done", done, 1'b0);
    chk("mid_reset err", err, 1'b0);
    rst = 1'b0; a = 1'b1; b = 1'b0;
    repeat (3) cycle();

`ifdef C3LIB_GF_CLKMUX_CTRL_TIMEOUT_EN
    // Clock A never turns off: timeout, ERR ignores requests, clear returns to idle.
    req = 1'b1; tgt = 1'b1;
    cycle();
    n = 1;
    req = 1'b0;
    while (err !== 1'b1 && n < 60) begin
      cycle();
      n++;
    end
    $display("timeout: err after %0d cycles", n);
    chk_int("timeout latency", n, 16);
    req = 1'b1; tgt = 1'b0;
    cycle();
    req = 1'b0;
    chk("err req sel", sel, 1'b1);
    chk("err busy", busy, 1'b1);
    chk("err sticky", err, 1'b1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    $display("err_clr: sel=%b busy=%b err=%b", sel, busy, err);
    chk("err_clr err", err, 1'b0);
    chk("err_clr busy", busy, 1'b0);
    chk("err_clr sel", sel, 1'b1);
`else
    // Stalled status with no timeout: wait forever, no error, clear ignored.
    req = 1'b1; tgt = 1'b1;
    cycle();
    req = 1'b0;
    bad_err = 0;
    bad_busy = 0;
    for (int i = 0; i < 5000; i++) begin
      clr = (i % 100 == 0);
      cycle();
      if (err !== 1'b0) bad_err++;
      if (busy !== 1'b1) bad_busy++;
    end
    clr = 1'b0;
    $display("stall: err=%b busy=%b after 5000 cycles", err, busy);
    chk_int("stall err cycles", bad_err, 0);
    chk_int("stall busy drops", bad_busy, 0);
    chk("stall err", err, 1'b0);
    chk("stall busy", busy, 1'b1);
`endif

    // Randomized traffic against the reference model.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 5) == 0);
      tgt = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) a = ~sel;
      if ($urandom_range(0, 3) == 0) b = sel;
      if ($urandom_range(0, 15) == 0) a = ~a;
      if ($urandom_range(0, 15) == 0) b = ~b;
      cycle();
      chk("rand sel", sel, m_sel);
      chk("rand busy", busy, m_phase != 0);
      chk("rand done", done, m_phase == 3);
      chk("rand err", err, m_phase == 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
